// File: rtl/mdu_unit.sv
// Multiply/divide unit with HI/LO result registers for the MIPS execute stage.
// Results are computed at issue, held for a fixed busy latency, then committed atomically.
module mdu_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  state_e             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0]   tmp_hi, tmp_hi_d;
  logic [WIDTH-1:0]   tmp_lo, tmp_lo_d;
  logic               tmp_wr, tmp_wr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, divisor_u;
  logic [WIDTH-1:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Signed division runs on magnitudes so the most-negative / -1 case wraps
  // to the most-negative quotient with zero remainder.
  always_comb begin
    prod_s    = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    prod_u    = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    b_zero    = (B == '0);
    a_neg     = A[WIDTH-1];
    b_neg     = B[WIDTH-1];
    mag_a     = a_neg ? -A : A;
    mag_b     = b_zero ? WIDTH'(1) : (b_neg ? -B : B);
    divisor_u = b_zero ? WIDTH'(1) : B;
    q_mag     = mag_a / mag_b;
    r_mag     = mag_a % mag_b;
    q_s       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r_s       = a_neg ? -r_mag : r_mag;
    q_u       = A / divisor_u;
    r_u       = A % divisor_u;
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    tmp_hi_d = tmp_hi;
    tmp_lo_d = tmp_lo;
    tmp_wr_d = tmp_wr;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT: begin
              tmp_hi_d = prod_s[2*WIDTH-1:WIDTH];
              tmp_lo_d = prod_s[WIDTH-1:0];
              tmp_wr_d = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = RUN;
            end
            OP_MULTU: begin
              tmp_hi_d = prod_u[2*WIDTH-1:WIDTH];
              tmp_lo_d = prod_u[WIDTH-1:0];
              tmp_wr_d = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = RUN;
            end
            OP_DIV: begin
              tmp_hi_d = r_s;
              tmp_lo_d = q_s;
              tmp_wr_d = !b_zero;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = RUN;
            end
            OP_DIVU: begin
              tmp_hi_d = r_u;
              tmp_lo_d = q_u;
              tmp_wr_d = !b_zero;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          state_d  = IDLE;
          cnt_d    = '0;
          tmp_wr_d = 1'b0;
        end else if (cnt == CNT_W'(1)) begin
          // A divide by zero runs the full latency but leaves HI/LO untouched.
          if (tmp_wr) begin
            hi_d = tmp_hi;
            lo_d = tmp_lo;
          end
          state_d  = IDLE;
          cnt_d    = '0;
          tmp_wr_d = 1'b0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      tmp_hi <= '0;
      tmp_lo <= '0;
      tmp_wr <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      tmp_hi <= tmp_hi_d;
      tmp_lo <= tmp_lo_d;
      tmp_wr <= tmp_wr_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy = (state == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
